shift_reg_sequencer: RTL and testbench
======================================

SHIFT_REG_SEQUENCER -- requirements
Module: shift_reg_sequencer

Interface
REQ-001 Parameter WIDTH, default 5: data width of the controlled shift register; WIDTH >= 2.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1): width of the shift-count fields.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  request accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-007 in_data  input  WIDTH  word to load.
REQ-008 in_count  input  CNT_W  number of shift pulses requested.
REQ-009 in_fill  input  1  serial fill bit for the whole job.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  result consumed when out_valid and out_ready are both 1 on a rising edge.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 abort  input  1  synchronous job cancel.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 sr_load, sr_shift  output  1 each  load and shift strobes to the shift register.
REQ-016 sr_load_data  output  WIDTH  load word to the shift register.
REQ-017 sr_shift_in  output  1  serial input to the shift register.
REQ-018 sr_out  input  WIDTH  current shift-register contents.

Function
REQ-019 FSM states: IDLE, LOAD, SHIFT, DONE; all state and registered outputs update on the rising edge of clk.
REQ-020 in_ready SHALL be 1 only in IDLE.
REQ-021 On accept, latch in_data, in_fill and the effective count; the effective count is min(in_count, WIDTH); next state is LOAD.
REQ-022 LOAD: sr_load=1 for exactly one cycle; sr_load_data = latched word; next state is SHIFT if the count is nonzero, else DONE.
REQ-023 SHIFT: sr_shift=1 every cycle; decrement the counter each cycle; go to DONE after exactly the effective count of pulses.
REQ-024 sr_shift_in = latched fill bit whenever sr_shift=1; sr_shift_in = 0 otherwise.
REQ-025 sr_load and sr_shift SHALL never both be 1, and both SHALL be 0 outside LOAD and SHIFT respectively.
REQ-026 DONE: out_valid=1 and out_data=sr_out; stay in DONE until out_ready=1, then go to IDLE.
REQ-027 out_data SHALL be 0 whenever out_valid=0.
REQ-028 Latency: for effective count N, the accept edge is cycle 0, the LOAD strobe is in cycle 1, the shifts are in cycles 2..N+1, and out_valid first rises in cycle N+2.
REQ-029 Back-to-back operation: after DONE->IDLE, in_ready=1 for at least one cycle; no request is accepted in the same cycle that DONE completes.
REQ-030 abort=1 in LOAD, SHIFT or DONE: the strobes deassert in the same cycle; next state is IDLE; no out_valid is produced.
REQ-031 abort=1 in IDLE SHALL be ignored, and abort takes priority over an in_valid/in_ready accept in the same cycle.
REQ-032 in_valid in non-IDLE states SHALL be ignored and SHALL not disturb the latched job.
REQ-033 The counter SHALL never wrap: no decrement at zero, and an in_count above WIDTH is clamped.

Reset
REQ-034 While rst=0 (asynchronously): state=IDLE, counter=0, latches=0, sr_load=0, sr_shift=0, sr_shift_in=0, sr_load_data=0, out_valid=0, out_data=0, busy=0, in_ready=0.
REQ-035 First edge after rst rises: in_ready=1.
REQ-036 Reset asserted mid-job discards the job; no further strobes are issued.

Verification (bench instantiates the team shift register, right-shift, WIDTH=5)
REQ-037 in_data=5'b10110, in_count=2, in_fill=1 -> load in cycle 1, shifts in cycles 2-3, out_valid in cycle 4 with out_data=5'b11101.
REQ-038 in_count=0, in_data=5'b01011 -> one load strobe, no shift strobe, out_valid in cycle 2 with out_data=5'b01011.
REQ-039 in_count=7, in_fill=0 -> exactly 5 shift strobes, out_data=5'b00000.
REQ-040 out_ready held 0 for 3 cycles in DONE -> out_valid and out_data stable; in_ready=0 throughout.
REQ-041 abort asserted on the second SHIFT cycle of a count-4 job -> no further sr_shift, busy=0 next cycle, out_valid never asserted.
REQ-042 rst driven low during SHIFT -> all outputs 0 immediately, without waiting for a clock edge; after release, a new job completes normally.

Source files
------------

// File: rtl/shift_reg_sequencer.sv
// Sequencer for an external shift register: accepts one job (load word, shift
// count, fill bit), loads it, issues the requested shift pulses, then presents the result.
module shift_reg_sequencer #(
    parameter int WIDTH = 5,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             abort,
    output logic             busy,
    output logic             sr_load,
    output logic             sr_shift,
    output logic [WIDTH-1:0] sr_load_data,
    output logic             sr_shift_in,
    input  logic [WIDTH-1:0] sr_out
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    logic             ready_en_q;
    logic             accept_s;

    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] req);
        if (req > CNT_MAX) begin
            return CNT_MAX;
        end else begin
            return req;
        end
    endfunction

    // State, job latches, and the post-reset enable that keeps in_ready low until the first edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            data_q     <= {WIDTH{1'b0}};
            fill_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            fill_q     <= fill_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic; abort wins over every other transition, including an accept.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        fill_d   = fill_q;
        accept_s = in_valid & in_ready;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    data_d  = in_data;
                    fill_d  = in_fill;
                    cnt_d   = clamp_count(in_count);
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else if (cnt_q != CNT_ZERO) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = CNT_ZERO;
                    end
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                if (abort || out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the registered state; abort masks strobes and the result at once.
    always_comb begin
        in_ready     = 1'b0;
        busy         = (state_q != ST_IDLE);
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_load_data = {WIDTH{1'b0}};
        sr_shift_in  = 1'b0;
        out_valid    = 1'b0;
        out_data     = {WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (ready_en_q && !abort) begin
                    in_ready = 1'b1;
                end else begin
                    in_ready = 1'b0;
                end
            end
            ST_LOAD: begin
                if (!abort) begin
                    sr_load      = 1'b1;
                    sr_load_data = data_q;
                end else begin
                    sr_load      = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (!abort && (cnt_q != CNT_ZERO)) begin
                    sr_shift    = 1'b1;
                    sr_shift_in = fill_q;
                end else begin
                    sr_shift    = 1'b0;
                end
            end
            ST_DONE: begin
                if (!abort) begin
                    out_valid = 1'b1;
                    out_data  = sr_out;
                end else begin
                    out_valid = 1'b0;
                end
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench: drives directed and random jobs through the sequencer
// attached to a right-shift register, comparing against an arithmetic model.
module tb_shift_reg_sequencer;

    localparam int W  = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_fill, out_valid, out_ready, abort, busy;
    logic [W-1:0]  in_data, out_data, sr_load_data, sr_out, sr_q;
    logic [CW-1:0] in_count;
    logic          sr_load, sr_shift, sr_shift_in;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_count(in_count), .in_fill(in_fill),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .abort(abort), .busy(busy),
        .sr_load(sr_load), .sr_shift(sr_shift), .sr_load_data(sr_load_data),
        .sr_shift_in(sr_shift_in), .sr_out(sr_out)
    );

    // Right-shift register the sequencer controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sr_q <= '0;
        else if (sr_load) sr_q <= sr_load_data;
        else if (sr_shift) sr_q <= {sr_shift_in, sr_q[W-1:1]};
    end
    assign sr_out = sr_q;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_count(input int n);
        return (n > W) ? W : n;
    endfunction

    // N right shifts with fill f: word moves down N places, top N bits become f.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input int n, input logic f);
        logic [W-1:0] ones;
        int e;
        ones = '1;
        e = eff_count(n);
        return (d >> e) | (f ? ~(ones >> e) : '0);
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_load"}, sr_load, 0);
        chk({tag, "_shift"}, sr_shift, 0);
        chk({tag, "_shift_in"}, sr_shift_in, 0);
        chk({tag, "_load_data"}, sr_load_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    // Runs one job starting at a negedge; abort_cyc = 0 means no abort.
    task automatic run_job(input logic [W-1:0] d, input int n, input logic f,
                           input int stall, input int abort_cyc, input bit noise);
        int e, g, last;
        logic [W-1:0] exp_res;
        e = eff_count(n);
        exp_res = ref_result(d, n, f);
        last = e + 2 + stall;
        g = 0;
        while (in_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        in_valid = 1'b1; in_data = d; in_count = CW'(n); in_fill = f;
        out_ready = 1'b0; abort = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            #1;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = W'($urandom_range(0, 31));
                in_count = CW'($urandom_range(0, 7));
                in_fill  = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c == abort_cyc) begin
                abort = 1'b1;
                #1;
                check_quiet("abort_now");
                chk("abort_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
                abort = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                chk("abort_busy", busy, 0);
                chk("abort_idle_ready", in_ready, 1);
                check_quiet("abort_next");
                @(negedge clk);
                check_quiet("abort_later");
                return;
            end
            chk("job_load", sr_load, (c == 1) ? 1 : 0);
            chk("job_load_data", sr_load_data, (c == 1) ? d : 0);
            chk("job_shift", sr_shift, (c >= 2 && c <= e + 1) ? 1 : 0);
            chk("job_shift_in", sr_shift_in, (c >= 2 && c <= e + 1) ? f : 0);
            chk("job_out_valid", out_valid, (c >= e + 2) ? 1 : 0);
            chk("job_out_data", out_data, (c >= e + 2) ? exp_res : 0);
            chk("job_busy", busy, 1);
            chk("job_in_ready", in_ready, 0);
            out_ready = (c == last) ? 1'b1 : 1'b0;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
        check_quiet("post");
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; in_fill = 1'b0;
        out_ready = 1'b0; abort = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        check_quiet("rst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready_first_edge", in_ready, 1);

        // Directed jobs from the reference scenarios.
        run_job(5'b10110, 2, 1'b1, 0, 0, 1'b0);
        run_job(5'b01011, 0, 1'b0, 0, 0, 1'b0);
        run_job(5'b11011, 7, 1'b0, 0, 0, 1'b0);
        run_job(5'b10011, 3, 1'b1, 3, 0, 1'b1);
        run_job(5'b01101, 4, 1'b1, 0, 3, 1'b0);
        run_job(5'b00111, 5, 1'b1, 1, 0, 1'b1);

        // Abort in IDLE is ignored but blocks a simultaneous accept.
        in_valid = 1'b1; in_data = 5'b11111; in_count = 3'd1; abort = 1'b1;
        #1;
        chk("idle_abort_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", busy, 0);
        chk("idle_abort_ready", in_ready, 1);
        check_quiet("idle_abort");

        // Reset mid-SHIFT clears outputs without a clock edge.
        in_valid = 1'b1; in_data = 5'b10101; in_count = 3'd4; in_fill = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_pre_shift", sr_shift, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        check_quiet("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rel_ready", in_ready, 1);
        chk("mid_rst_rel_busy", busy, 0);
        check_quiet("mid_rst_rel");
        run_job(5'b01110, 2, 1'b0, 0, 0, 1'b0);

        // Random jobs with noise on the request port, stalls and occasional aborts.
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] rd;
            int rn, ab;
            rd = W'($urandom_range(0, 31));
            rn = $urandom_range(0, 7);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, eff_count(rn) + 2) : 0;
            run_job(rd, rn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), ab, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
